// File: rtl/dspl_pkg.sv
// Shared types and constants for the display arbiter: digit word layout,
// power-level segment codes and the arbiter state encoding.
package dspl_pkg;

    localparam int unsigned FRAME_W = 48;
    localparam int unsigned DIG_W   = 6;
    localparam int unsigned NUM_DIG = FRAME_W / DIG_W;
    localparam int unsigned EN_BIT  = 5;
    localparam int unsigned DP_BIT  = 0;

    localparam logic [3:0] CODE_POT_LOW  = 4'hA;
    localparam logic [3:0] CODE_POT_MED  = 4'hB;
    localparam logic [3:0] CODE_POT_HIGH = 4'hC;

    typedef enum logic {ST_BG, ST_MSG} state_t;

    // One digit word as seen by the display driver: {en, code, dp}
    typedef struct packed {
        logic       en;
        logic [3:0] code;
        logic       dp;
    } digit_t;

    // d1 sits in the least significant slot
    typedef digit_t [NUM_DIG-1:0] frame_t;

    // Blanks masked digits while the blink phase is in its hidden half
    function automatic frame_t apply_blink(input frame_t frame,
                                           input logic [NUM_DIG-1:0] mask,
                                           input logic phase);
        frame_t shown;
        shown = frame;
        for (int i = 0; i < int'(NUM_DIG); i++) begin
            if (mask[i] && !phase) begin
                shown[i].en = 1'b0;
            end
        end
        return shown;
    endfunction

endpackage

// File: rtl/dspl_ms_tick.sv
// Millisecond prescaler: free-running 0..TICK_COUNT-1 counter with a
// one-cycle tick on the terminal count; clear restarts the count at zero.
module dspl_ms_tick #(
    parameter int unsigned TICK_COUNT = 100000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick_c
);

    localparam int unsigned PRE_W = ($clog2(TICK_COUNT) > 0) ? $clog2(TICK_COUNT) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_COUNT - 1);

    logic [PRE_W-1:0] count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear || (count == PRE_LAST)) begin
            count <= '0;
        end else begin
            count <= count + PRE_W'(1);
        end
    end

    assign tick_c = (count == PRE_LAST);

endmodule

// File: rtl/dspl_arbiter.sv
// Display arbiter: shows the blinking background frame unless a message is
// accepted, then holds the message for HOLD_MS ms. Define DSPL_MSG_BLINK_EN to blink messages too.
module dspl_arbiter
    import dspl_pkg::*;
#(
    parameter int unsigned TICK_COUNT = 100000,
    parameter int unsigned HOLD_MS    = 2000,
    parameter int unsigned BLINK_MS   = 500
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [FRAME_W-1:0] bg_frame,
    input  logic [NUM_DIG-1:0] bg_blink_mask,
    input  logic               msg_req,
    input  logic [FRAME_W-1:0] msg_frame,
    input  logic               msg_cancel,
    output logic               msg_ack,
    output logic               msg_busy,
    output logic               src,
    output logic [DIG_W-1:0]   d1,
    output logic [DIG_W-1:0]   d2,
    output logic [DIG_W-1:0]   d3,
    output logic [DIG_W-1:0]   d4,
    output logic [DIG_W-1:0]   d5,
    output logic [DIG_W-1:0]   d6,
    output logic [DIG_W-1:0]   d7,
    output logic [DIG_W-1:0]   d8
);

    localparam int unsigned HOLD_W  = ($clog2(HOLD_MS) > 0) ? $clog2(HOLD_MS) : 1;
    localparam int unsigned BLINK_W = ($clog2(BLINK_MS) > 0) ? $clog2(BLINK_MS) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_MS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_MS - 1);

    state_t              state;
    frame_t              msg_buf;
    frame_t              disp;
    logic [HOLD_W-1:0]   hold;
    logic [BLINK_W-1:0]  blink_cnt;
    logic                phase;

    logic   tick_c;
    logic   expire_c;
    frame_t bg_shown_c;
    frame_t msg_shown_c;

    // Acceptance restarts the ms grid so the hold time is exact
    dspl_ms_tick #(
        .TICK_COUNT(TICK_COUNT)
    ) u_ms_tick (
        .clock (clock),
        .reset (reset),
        .clear (msg_req),
        .tick_c(tick_c)
    );

    assign expire_c   = (state == ST_MSG) && tick_c && (hold == HOLD_LAST);
    assign bg_shown_c = apply_blink(bg_frame, bg_blink_mask, phase);

`ifdef DSPL_MSG_BLINK_EN
    assign msg_shown_c = apply_blink(msg_buf, '1, phase);
`else
    assign msg_shown_c = msg_buf;
`endif

    // Blink phase: toggles every BLINK_MS ticks, restarts visible on acceptance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (msg_req) begin
            blink_cnt <= '0;
            phase     <= 1'b1;
        end else if (tick_c) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // Arbitration FSM; a new request beats both cancel and hold expiry
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_BG;
            msg_buf  <= '0;
            disp     <= '0;
            hold     <= '0;
            msg_ack  <= 1'b0;
            msg_busy <= 1'b0;
            src      <= 1'b0;
        end else begin
            msg_ack <= 1'b0;
            if (msg_req) begin
                state    <= ST_MSG;
                msg_buf  <= msg_frame;
                disp     <= msg_frame;
                hold     <= '0;
                msg_ack  <= 1'b1;
                msg_busy <= 1'b1;
                src      <= 1'b1;
            end else if ((state == ST_MSG) && !msg_cancel && !expire_c) begin
                if (tick_c) begin
                    hold <= hold + HOLD_W'(1);
                end
                disp <= msg_shown_c;
            end else begin
                state    <= ST_BG;
                disp     <= bg_shown_c;
                msg_busy <= 1'b0;
                src      <= 1'b0;
            end
        end
    end

    assign d1 = disp[0];
    assign d2 = disp[1];
    assign d3 = disp[2];
    assign d4 = disp[3];
    assign d5 = disp[4];
    assign d6 = disp[5];
    assign d7 = disp[6];
    assign d8 = disp[7];

endmodule
